// File: rtl/maxpool_seq_ctrl.sv
// Sequencer for a WIN x WIN, stride-1 max-pool engine: streams the window taps out of
// a 1-cycle-latency source RAM and writes each window maximum in raster order.
module maxpool_seq_ctrl #(
    parameter int DATA_W = 8,
    parameter int IN_W   = 8,
    parameter int IN_H   = 8,
    parameter int WIN    = 3,
    parameter int RD_AW  = 6,
    parameter int WR_AW  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [RD_AW-1:0]  rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_en,
    output logic [WR_AW-1:0]  wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              wr_ready
);

    localparam int OUT_W = IN_W - WIN + 1;
    localparam int OUT_H = IN_H - WIN + 1;
    localparam int NTAP  = WIN * WIN;
    localparam int TAP_W = $clog2(NTAP + 1);
    localparam int I_W   = (OUT_H > 1) ? $clog2(OUT_H) : 1;
    localparam int J_W   = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_DRAIN = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [I_W-1:0]     i_q, i_d;
    logic [J_W-1:0]     j_q, j_d;
    logic [TAP_W-1:0]   tap_q, tap_d;
    logic [DATA_W-1:0]  max_q, max_d;

    logic               last_out_s;
    logic               gt_s;
    logic [RD_AW-1:0]   row_s;
    logic [RD_AW-1:0]   col_s;

    assign last_out_s = (i_q == I_W'(OUT_H - 1)) && (j_q == J_W'(OUT_W - 1));
    assign gt_s       = (rd_data > max_q);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            tap_q   <= '0;
            max_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            tap_q   <= tap_d;
            max_q   <= max_d;
        end
    end

    // Next-state and counter/accumulator update
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        tap_d   = tap_q;
        max_d   = max_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_READ;
                    i_d     = '0;
                    j_d     = '0;
                    tap_d   = '0;
                    max_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                tap_d = tap_q + TAP_W'(1);
                // rd_data belongs to the previous tap, so tap 0 has nothing to fold in yet
                if ((tap_q != '0) && gt_s) begin
                    max_d = rd_data;
                end else begin
                    max_d = max_q;
                end
                if (tap_q == TAP_W'(NTAP - 1)) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_READ;
                end
            end
            S_DRAIN: begin
                if (gt_s) begin
                    max_d = rd_data;
                end else begin
                    max_d = max_q;
                end
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (wr_ready) begin
                    max_d = '0;
                    tap_d = '0;
                    if (last_out_s) begin
                        state_d = S_DONE;
                        i_d     = '0;
                        j_d     = '0;
                    end else if (j_q == J_W'(OUT_W - 1)) begin
                        state_d = S_READ;
                        j_d     = '0;
                        i_d     = i_q + I_W'(1);
                    end else begin
                        state_d = S_READ;
                        j_d     = j_q + J_W'(1);
                    end
                end else begin
                    state_d = S_WRITE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign row_s = RD_AW'(i_q) + RD_AW'(tap_q / TAP_W'(WIN));
    assign col_s = RD_AW'(j_q) + RD_AW'(tap_q % TAP_W'(WIN));

    // Moore outputs decoded from registered state; idle values are all zero
    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        rd_en   = 1'b0;
        rd_addr = '0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        case (state_q)
            S_READ: begin
                busy    = 1'b1;
                rd_en   = 1'b1;
                rd_addr = row_s * RD_AW'(IN_W) + col_s;
            end
            S_DRAIN: begin
                busy = 1'b1;
            end
            S_WRITE: begin
                busy    = 1'b1;
                wr_en   = 1'b1;
                wr_addr = WR_AW'(i_q) * WR_AW'(OUT_W) + WR_AW'(j_q);
                wr_data = max_q;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/maxpool_seq_ctrl.md
Name: maxpool_seq_ctrl

Overview:
Sequencer for the 3x3, stride-1 max-pool window engine. It reads an IN_H x IN_W feature map from a single-port source RAM (1-cycle read latency), one pixel per cycle. It computes each window maximum and writes the OUT_H x OUT_W pooled map to a destination buffer in raster order. Software starts a job with a start/done handshake; the destination buffer can apply backpressure through wr_ready.

Parameters:
- DATA_W, 8, pixel width (unsigned).
- IN_W, 8, feature-map width.
- IN_H, 8, feature-map height.
- WIN, 3, square window size. OUT_W = IN_W-WIN+1 and OUT_H = IN_H-WIN+1 (6x6 at defaults).
- RD_AW, 6, read address width; must be >= clog2(IN_W*IN_H).
- WR_AW, 6, write address width; must be >= clog2(OUT_W*OUT_H).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  job request; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until DONE exits.
- done  out  1  single-cycle pulse when the last result is written.
- rd_en  out  1  source RAM read strobe.
- rd_addr  out  RD_AW  source address = row*IN_W + col.
- rd_data  in  DATA_W  source data, valid the cycle after rd_en.
- wr_en  out  1  destination write request.
- wr_addr  out  WR_AW  destination address = i*OUT_W + j.
- wr_data  out  DATA_W  window maximum.
- wr_ready  in  1  destination accepts the write when wr_en && wr_ready.

Behaviour:
- Reset values: busy=0, done=0, rd_en=0, rd_addr=0, wr_en=0, wr_addr=0, wr_data=0. State=IDLE; counters i, j, tap=0; max accumulator=0.
- States and transitions:
  - IDLE -> READ when start=1. Clear i, j, tap and max.
  - READ: lasts exactly WIN*WIN cycles (taps 0..8).
    - Each cycle: rd_en=1, rd_addr=(i+tap/WIN)*IN_W + (j+tap%WIN).
    - tap increments each cycle.
    - From the second READ cycle on, the returned rd_data (previous tap) is compared into max.
  - READ -> DRAIN after tap 8 is issued.
  - DRAIN: one cycle, rd_en=0. Capture the tap-8 data into max.
  - DRAIN -> WRITE.
  - WRITE: wr_en=1, wr_addr=i*OUT_W+j, wr_data=max. All three hold stable until wr_ready=1.
    - On handshake: advance j, wrapping to 0 and incrementing i at OUT_W-1. Clear max and tap.
    - Go to READ, or to DONE if (i,j) was (OUT_H-1, OUT_W-1).
  - DONE: done=1 for one cycle, busy=0 in this cycle. DONE -> IDLE.
- Arithmetic:
  - Unsigned compare; strictly-greater updates max.
  - max starts at 0, so an all-zero window yields 0.
  - Addresses are computed in RD_AW/WR_AW bits; at legal parameters no overflow is possible.
- Latency (wr_ready tied high):
  - Start accepted at cycle t0 (IDLE, start=1).
  - First READ at t0+1; first write handshake at t0+11.
  - 11 cycles per output. The last write is at t0+396 (6x6) and done pulses at t0+397.
- Backpressure: each cycle of wr_ready=0 in WRITE adds one cycle. No reads are issued while stalled.
- start while busy, or in DONE, is ignored. There is no queuing.
- rst mid-job: next cycle is IDLE with all outputs at reset values. No further reads or writes occur, and done is not pulsed.
- Exactly OUT_W*OUT_H write handshakes per job, in strictly increasing wr_addr order, with no duplicates.
- rd_en is never asserted outside READ. wr_en is never asserted outside WRITE.

Test Plan:
- All-zero feature map, wr_ready=1, start pulse -> 36 writes, addr 0..35, all data 0x00. done pulses exactly at t0+397, busy high t0+1..t0+396.
- Ramp map, pixel[r][c]=r*8+c -> wr_data at addr i*6+j = (i+2)*8+(j+2). For example, addr 0=18, addr 35=63.
- Single hot pixel 0xFF at (3,4), others 0x01 -> outputs with i in 1..3 and j in 2..4 are 0xFF (9 entries), the remaining 27 are 0x01. Check rd_addr sequence for output 0 is 0,1,2,8,9,10,16,17,18.
- wr_ready low for 5 cycles on every third write -> wr_addr/wr_data stable while stalled, no rd_en during stall. Result set identical to the no-stall run, and done is delayed by 5 cycles per stalled write.
- rst asserted 150 cycles into a job -> outputs at reset values the next cycle, no done pulse. A fresh start then completes a full correct 36-write job.
- start held high through an entire job -> exactly one job runs; IDLE re-accepts start the cycle after done, and a second job begins with a read of rd_addr 0.
